// File: rtl/cmp_eq_serial_pkg.sv
// Shared types and sizing helpers for the chunk-serial equality comparator.
package cmp_eq_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Slice counter width; a single-slice word still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_eq_serial_cmpeq.sv
// Combinational full-width equality: XNOR of corresponding bits, AND-reduced.
module CmpEQ #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             eq
);

  assign eq = &(a ~^ b);

endmodule

// File: rtl/cmp_eq_serial.sv
// Chunk-serial equality comparator: consumes N slice pairs LSB-first and
// returns one full-word EQ flag over a valid/ready result handshake.
module cmp_eq_serial
  import cmp_eq_serial_pkg::*;
#(
  parameter int width = 32,
  parameter int chunk = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Abort,
  input  logic             InValid,
  output logic             InReady,
  input  logic [chunk-1:0] A,
  input  logic [chunk-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             EQ
);

  localparam int CHUNK_NZ = (chunk < 1) ? 1 : chunk;
  localparam int N        = width / CHUNK_NZ;
  localparam int CW       = cnt_width(N);

  if (chunk < 1) begin : g_bad_chunk
    $error("cmp_eq_serial: chunk must be >= 1");
  end
  if ((width % CHUNK_NZ) != 0 || width < CHUNK_NZ) begin : g_bad_width
    $error("cmp_eq_serial: width must be a positive multiple of chunk");
  end

  state_e          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            eq_acc, eq_acc_d;
  logic            slice_eq;
  logic            in_xfer, out_xfer;

  CmpEQ #(.width(chunk)) u_slice_cmp (
    .a  (A),
    .b  (B),
    .eq (slice_eq)
  );

  // Outputs decode only the state register and eq_acc, never the inputs.
  assign InReady  = (state != RESULT);
  assign OutValid = (state == RESULT);
  assign EQ       = OutValid & eq_acc;

  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      cnt    <= '0;
      eq_acc <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      eq_acc <= eq_acc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    eq_acc_d = eq_acc;

    if (Abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      eq_acc_d = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            eq_acc_d = slice_eq;
            cnt_d    = CW'(1);
            state_d  = (N > 1) ? ACCUM : RESULT;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            eq_acc_d = eq_acc & slice_eq;
            // The last slice holds cnt so it cannot wrap by overflow when N
            // is a power of two; RESULT->IDLE clears it.
            if (cnt == CW'(N - 1)) begin
              state_d = RESULT;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        RESULT: begin
          if (out_xfer) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_eq_serial.sv
// Bench for cmp_eq_serial: a 32/8 instance and an 8/8 (N=1) instance, each
// checked every cycle against a word-level model, plus directed literal checks.
module tb_cmp_eq_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic [7:0] a, b;

  logic in_valid_w, in_ready_w, out_valid_w, out_ready_w, eq_w;
  logic in_valid_s, in_ready_s, out_valid_s, out_ready_s, eq_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_eq_serial #(.width(32), .chunk(8)) dut_w (
    .CLK      (clk),
    .RSTn     (rst_n),
    .Abort    (abort),
    .InValid  (in_valid_w),
    .InReady  (in_ready_w),
    .A        (a),
    .B        (b),
    .OutValid (out_valid_w),
    .OutReady (out_ready_w),
    .EQ       (eq_w)
  );

  cmp_eq_serial #(.width(8), .chunk(8)) dut_s (
    .CLK      (clk),
    .RSTn     (rst_n),
    .Abort    (abort),
    .InValid  (in_valid_s),
    .InReady  (in_ready_s),
    .A        (a),
    .B        (b),
    .OutValid (out_valid_s),
    .OutReady (out_ready_s),
    .EQ       (eq_s)
  );

  // Word-level model: collect slices into whole words, compare whole words.
  typedef struct {
    int          cnt;
    logic [31:0] wa;
    logic [31:0] wb;
    bit          pend;
    bit          res;
  } model_t;

  model_t mw, ms;

  function automatic model_t m_reset();
    model_t m;
    m.cnt = 0; m.wa = '0; m.wb = '0; m.pend = 1'b0; m.res = 1'b0;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input int n, input bit inv,
                                  input bit ordy, input logic [7:0] sa,
                                  input logic [7:0] sb, input bit ab);
    if (ab) begin
      m = m_reset();
    end else if (m.pend) begin
      if (ordy) m.pend = 1'b0;
    end else if (inv) begin
      m.wa[8*m.cnt +: 8] = sa;
      m.wb[8*m.cnt +: 8] = sb;
      m.cnt++;
      if (m.cnt == n) begin
        m.res  = (m.wa == m.wb);
        m.pend = 1'b1;
        m.cnt  = 0;
        m.wa   = '0;
        m.wb   = '0;
      end
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are checked at every falling edge, then the
  // model absorbs the inputs that the next rising edge will sample.
  initial begin
    mw = m_reset();
    ms = m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mw = m_reset();
        ms = m_reset();
      end
      check("w_in_ready",  in_ready_w,  !mw.pend);
      check("w_out_valid", out_valid_w, mw.pend);
      check("w_eq",        eq_w,        mw.pend & mw.res);
      check("s_in_ready",  in_ready_s,  !ms.pend);
      check("s_out_valid", out_valid_s, ms.pend);
      check("s_eq",        eq_s,        ms.pend & ms.res);
      if (rst_n) begin
        mw = step(mw, 4, in_valid_w, out_ready_w, a, b, abort);
        ms = step(ms, 1, in_valid_s, out_ready_s, a, b, abort);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one 32-bit word as four slices, with an optional gap before slice 3.
  task automatic send_word32(input logic [31:0] wa, input logic [31:0] wb, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          in_valid_w = 1'b0;
          tick();
          check("gap_no_result", out_valid_w, 1'b0);
        end
      end
      in_valid_w = 1'b1;
      a = wa[8*i +: 8];
      b = wb[8*i +: 8];
      tick();
    end
    in_valid_w = 1'b0;
    check("latency_out_valid", out_valid_w, 1'b1);
    check("latency_in_ready",  in_ready_w,  1'b0);
  endtask

  task automatic get_result32(input string name, input bit exp_eq, input int stall);
    int k;
    for (int s = 0; s < stall; s++) begin
      out_ready_w = 1'b0;
      tick();
      check("stall_out_valid", out_valid_w, 1'b1);
      check("stall_eq",        eq_w,        exp_eq);
      check("stall_in_ready",  in_ready_w,  1'b0);
    end
    k = 0;
    while (!out_valid_w && k < 20) begin
      tick();
      k++;
    end
    check("result_timeout", out_valid_w, 1'b1);
    check(name, eq_w, exp_eq);
    out_ready_w = 1'b1;
    tick();
    out_ready_w = 1'b0;
    check("ready_after_xfer", in_ready_w, 1'b1);
    check("valid_after_xfer", out_valid_w, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; a = '0; b = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0;
    in_valid_s = 1'b0; out_ready_s = 1'b0;
    #1;
    check("rst_in_ready",  in_ready_w,  1'b1);
    check("rst_out_valid", out_valid_w, 1'b0);
    check("rst_eq",        eq_w,        1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    send_word32(32'hDEADBEEF, 32'hDEADBEEF, 0);
    get_result32("eq_deadbeef", 1'b1, 0);
    send_word32(32'h12345678, 32'h12345679, 0);
    get_result32("ne_lsb_slice", 1'b0, 0);
    send_word32(32'h12345678, 32'h92345678, 0);
    get_result32("ne_msb_slice", 1'b0, 0);
    send_word32(32'hCAFEF00D, 32'hCAFEF00D, 3);
    get_result32("eq_gap_stall", 1'b1, 5);

    // Abort after two slices, the third slice offered alongside the abort.
    in_valid_w = 1'b1; a = 8'hFF; b = 8'h00; tick();
    a = 8'h11; b = 8'h11; tick();
    abort = 1'b1; a = 8'h22; b = 8'h33; tick();
    abort = 1'b0; in_valid_w = 1'b0;
    check("abort_in_ready",  in_ready_w,  1'b1);
    check("abort_out_valid", out_valid_w, 1'b0);
    send_word32(32'h0, 32'h0, 0);
    get_result32("eq_after_abort", 1'b1, 0);

    // Abort wins over a simultaneous output transfer.
    send_word32(32'h0000_0001, 32'h0, 0);
    abort = 1'b1; out_ready_w = 1'b1; tick();
    abort = 1'b0; out_ready_w = 1'b0;
    check("abort_drops_result", out_valid_w, 1'b0);

    // Asynchronous reset mid-word.
    in_valid_w = 1'b1; a = 8'h01; b = 8'h02; tick(); tick();
    in_valid_w = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midword_rst_in_ready",  in_ready_w,  1'b1);
    check("midword_rst_out_valid", out_valid_w, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word32(32'h5555AAAA, 32'h5555AAAA, 0);
    get_result32("eq_after_reset", 1'b1, 0);

    // Single-slice instance.
    in_valid_s = 1'b1; a = 8'h5A; b = 8'h5A; tick();
    in_valid_s = 1'b0;
    check("n1_out_valid", out_valid_s, 1'b1);
    check("n1_eq",        eq_s,        1'b1);
    out_ready_s = 1'b1; tick(); out_ready_s = 1'b0;
    check("n1_in_ready",  in_ready_s,  1'b1);
    in_valid_s = 1'b1; a = 8'h5A; b = 8'hA5; tick();
    in_valid_s = 1'b0;
    check("n1_ne_out_valid", out_valid_s, 1'b1);
    check("n1_ne",           eq_s,        1'b0);
    out_ready_s = 1'b1; tick(); out_ready_s = 1'b0;

    // Random traffic on both instances; the compare process does the checking.
    for (int c = 0; c < 4000; c++) begin
      a = 8'($urandom);
      b = ($urandom_range(4, 0) == 0) ? (a ^ (8'h01 << $urandom_range(7, 0))) : a;
      in_valid_w  = ($urandom_range(9, 0) < 7);
      in_valid_s  = ($urandom_range(9, 0) < 7);
      out_ready_w = ($urandom_range(9, 0) < 6);
      out_ready_s = ($urandom_range(9, 0) < 6);
      abort       = ($urandom_range(59, 0) == 0);
      rst_n       = ($urandom_range(499, 0) != 0);
      tick();
    end
    rst_n = 1'b1; abort = 1'b0; in_valid_w = 1'b0; in_valid_s = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
